// File: rtl/uart_bridge_pkg.sv
// Shared types and widths for the UART word bridge.
package uart_bridge_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
   localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_SEND = 1'b1
   } tx_state_t;

endpackage

// File: rtl/uart_word_bridge_if.sv
// Byte-side, router-side and status signals of the UART word bridge.
interface uart_word_bridge_if;
   import uart_bridge_pkg::*;

   logic [BYTE_W-1:0] rx_byte_i;
   logic              rx_valid_i;
   logic [WORD_W-1:0] command_word_o;
   logic              command_valid_o;
   logic              command_ready_i;
   logic [WORD_W-1:0] command_word_i;
   logic              command_valid_i;
   logic              command_ready_o;
   logic [BYTE_W-1:0] tx_byte_o;
   logic              tx_valid_o;
   logic              tx_ready_i;
   logic              overflow_o;
   logic              rx_timeout_o;

   modport master (
      output rx_byte_i, rx_valid_i, command_ready_i, command_word_i,
             command_valid_i, tx_ready_i,
      input  command_word_o, command_valid_o, command_ready_o, tx_byte_o,
             tx_valid_o, overflow_o, rx_timeout_o
   );

   modport slave (
      input  rx_byte_i, rx_valid_i, command_ready_i, command_word_i,
             command_valid_i, tx_ready_i,
      output command_word_o, command_valid_o, command_ready_o, tx_byte_o,
             tx_valid_o, overflow_o, rx_timeout_o
   );

endinterface

// File: rtl/uart_word_fifo.sv
// Synchronous word FIFO; pointers carry an extra wrap bit to tell full from empty.
module uart_word_fifo
   import uart_bridge_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [WORD_W-1:0] push_data,
   input  logic              pop,
   output logic [WORD_W-1:0] head,
   output logic              full,
   output logic              empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [WORD_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              do_push_c;
   logic              do_pop_c;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head      = mem[rd_ptr[AW-1:0]];
   assign do_pop_c  = pop && !empty;
   // A pop frees the slot the simultaneous push needs, so full only blocks a lone push.
   assign do_push_c = push && (!full || do_pop_c);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push_c) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + PW'(1);
         end
         if (do_pop_c) rd_ptr <= rd_ptr + PW'(1);
      end
   end

endmodule

// File: rtl/uart_word_bridge.sv
// UART byte <-> 32-bit router word bridge: RX packer + FIFO, TX unpacker FSM.
// Optional inter-byte RX timeout enabled with `define UART_RX_TIMEOUT_EN.
module uart_word_bridge
   import uart_bridge_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input logic               clk,
   input logic               reset,
   uart_word_bridge_if.slave bus
);

   logic [LANE_W-1:0] rx_cnt;
   logic [WORD_W-1:0] rx_word;
   logic [WORD_W-1:0] push_word_c;
   logic [LANE_W-1:0] eff_lane_c;
   logic              push_c;
   logic              pop_c;
   logic              fifo_full;
   logic              fifo_empty;
   logic              overflow_q;
   logic              rx_timeout_c;

   // A timeout in the same cycle as a byte restarts the word at lane 0.
   always_comb begin
      eff_lane_c  = rx_timeout_c ? '0 : rx_cnt;
      push_word_c = rx_word;
      push_word_c[32'(eff_lane_c) * BYTE_W +: BYTE_W] = bus.rx_byte_i;
      push_c      = bus.rx_valid_i && (eff_lane_c == LANE_W'(BYTES_PER_WORD - 1));
   end

   assign pop_c = !fifo_empty && bus.command_ready_i;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_cnt     <= '0;
         rx_word    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (bus.rx_valid_i) begin
            rx_word <= push_word_c;
            rx_cnt  <= eff_lane_c + LANE_W'(1);
         end else if (rx_timeout_c) begin
            rx_cnt <= '0;
         end
         if (push_c && fifo_full && !pop_c) overflow_q <= 1'b1;
      end
   end

`ifdef UART_RX_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

   logic [TO_W-1:0] to_cnt;
   logic            rx_timeout_q;

   assign rx_timeout_c = (rx_cnt != '0) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_cnt       <= '0;
         rx_timeout_q <= 1'b0;
      end else begin
         rx_timeout_q <= rx_timeout_c;
         if (bus.rx_valid_i || (rx_cnt == '0) || rx_timeout_c) to_cnt <= '0;
         else                                                   to_cnt <= to_cnt + TO_W'(1);
      end
   end

   assign bus.rx_timeout_o = rx_timeout_q;
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
   assign rx_timeout_c       = 1'b0;
   assign bus.rx_timeout_o   = 1'b0;
`endif

   uart_word_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_c),
      .push_data (push_word_c),
      .pop       (pop_c),
      .head      (bus.command_word_o),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign bus.command_valid_o = !fifo_empty;
   assign bus.overflow_o      = overflow_q;

   tx_state_t         tx_state;
   logic [WORD_W-1:0] tx_word;
   logic [LANE_W-1:0] tx_idx;
   logic [LANE_W-1:0] tx_next_idx_c;
   logic              cmd_ready_q;
   logic              tx_valid_q;
   logic [BYTE_W-1:0] tx_byte_q;

   assign tx_next_idx_c = tx_idx + LANE_W'(1);

   // TX unpacker: latch one router word, then emit its lanes little-endian.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state    <= TX_IDLE;
         tx_word     <= '0;
         tx_idx      <= '0;
         cmd_ready_q <= 1'b1;
         tx_valid_q  <= 1'b0;
         tx_byte_q   <= '0;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (bus.command_valid_i) begin
                  tx_word     <= bus.command_word_i;
                  tx_idx      <= '0;
                  tx_byte_q   <= bus.command_word_i[BYTE_W-1:0];
                  tx_valid_q  <= 1'b1;
                  cmd_ready_q <= 1'b0;
                  tx_state    <= TX_SEND;
               end
            end
            TX_SEND: begin
               if (bus.tx_ready_i) begin
                  if (tx_idx == LANE_W'(BYTES_PER_WORD - 1)) begin
                     tx_valid_q  <= 1'b0;
                     tx_byte_q   <= '0;
                     cmd_ready_q <= 1'b1;
                     tx_state    <= TX_IDLE;
                  end else begin
                     tx_idx    <= tx_next_idx_c;
                     tx_byte_q <= tx_word[32'(tx_next_idx_c) * BYTE_W +: BYTE_W];
                  end
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   assign bus.command_ready_o = cmd_ready_q;
   assign bus.tx_valid_o      = tx_valid_q;
   assign bus.tx_byte_o       = tx_byte_q;

endmodule

// File: doc/uart_word_bridge.md
# uart_word_bridge

Byte/word adaptation stage between the UART PHY and `uart_router`. The RX path packs byte strobes from the UART receiver into 32-bit command words, buffers them in a small FIFO and presents them on a valid/ready port that feeds the router's command input. The TX path accepts 32-bit words from the router's command output and serialises them into bytes for the UART transmitter.

## Interface
- `FIFO_DEPTH`, 4: RX word FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 100000: inter-byte timeout in `clk` cycles; only used with `UART_RX_TIMEOUT_EN`.
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `rx_byte_i`  in  8  received byte.
- `rx_valid_i`  in  1  one-cycle strobe; no backpressure possible.
- `command_word_o`  out  32  packed word to router.
- `command_valid_o`  out  1  FIFO non-empty.
- `command_ready_i`  in  1  router accepts word.
- `command_word_i`  in  32  word from router.
- `command_valid_i`  in  1  router word valid.
- `command_ready_o`  out  1  bridge accepts router word.
- `tx_byte_o`  out  8  byte to UART TX.
- `tx_valid_o`  out  1  byte valid.
- `tx_ready_i`  in  1  UART TX accepts byte.
- `overflow_o`  out  1  sticky: a complete word was dropped.
- `rx_timeout_o`  out  1  one-cycle pulse: partial word discarded.

## Operation
- RX packer: 2-bit lane counter `rx_cnt`, 32-bit assembly register. Little-endian: first byte → [7:0], fourth → [31:24].
- On `rx_valid_i`: byte written into lane `rx_cnt`; `rx_cnt` increments modulo 4. On the fourth byte the completed word (including the current byte) is pushed into the FIFO.
- FIFO full on push: word dropped, `overflow_o` set, held until reset. Push and pop in the same cycle while full: both occur, no drop, occupancy unchanged. Push and pop while empty: the word is not visible until the next cycle.
- FIFO head drives `command_word_o`. Pop on `command_valid_o && command_ready_i`. `command_word_o` is don't-care when empty.
- TX unpacker FSM, states `TX_IDLE`, `TX_SEND`:
  - `TX_IDLE`: `command_ready_o`=1. On `command_valid_i`, latch the word, `tx_idx`=0, go to `TX_SEND`.
  - `TX_SEND`: `command_ready_o`=0, `tx_valid_o`=1, `tx_byte_o` = latched word lane `tx_idx` (little-endian). On `tx_ready_i`, `tx_idx`++. On acceptance of lane 3, go to `TX_IDLE`.
- RX and TX paths are fully independent.

## Timing
- Reset (async assert, sync-safe deassert): `rx_cnt`=0, FIFO empty, `command_valid_o`=0, `command_ready_o`=1 (`TX_IDLE`), `tx_valid_o`=0, `tx_byte_o`=0, `overflow_o`=0, `rx_timeout_o`=0, `command_word_o`=0. Reset mid-word or mid-send discards all partial state; nothing is resumed.
- RX latency: `command_valid_o` rises the cycle after the fourth `rx_valid_i` strobe when the FIFO was empty.
- RX throughput: one word per cycle from the FIFO. Sustained input is limited only by the UART byte rate.
- TX: each byte is held stable while `tx_valid_o && !tx_ready_i`. Minimum 5 cycles per word: 1 accept cycle plus 4 byte cycles.
- Router valid/ready: a transfer occurs only when valid and ready are both high on the same `clk` edge. `command_valid_o` never deasserts without a pop.

## Configuration
- `UART_RX_TIMEOUT_EN` defined:
  - A cycle counter runs while `rx_cnt`≠0 and clears on every `rx_valid_i`.
  - When it reaches `TIMEOUT_CYCLES`−1: `rx_cnt`←0, the partial word is discarded, and `rx_timeout_o` pulses for 1 cycle.
  - A byte arriving in the same cycle as the timeout starts a new word at lane 0.
- Undefined: no counter; `rx_timeout_o` tied 0; a partial word waits indefinitely.

## Structure
- `uart_bridge_pkg`: `tx_state_t` enum, `BYTES_PER_WORD`=4, `BYTE_W`=8.
- Sub-module `uart_word_fifo`: synchronous FIFO with `FIFO_DEPTH` entries, 32-bit data, `full`/`empty`, pointers one bit wider than the address. Packer and unpacker FSM stay in the top level.

## Test plan
- Bytes 0x78,0x56,0x34,0x12 with ready=1 → `command_word_o`=0x12345678, valid 1 cycle after the last strobe, popped next edge.
- `command_ready_i`=0, FIFO_DEPTH=4, 5 words streamed → 4 retained in order, fifth dropped, `overflow_o`=1 and stays 1 after the FIFO drains.
- FIFO full, fourth byte arrives in the same cycle as a pop → no overflow, occupancy stays 4, word order preserved.
- Router word 0xDEADBEEF, `tx_ready_i` toggling 1,0,1,… → bytes EF,BE,AD,DE each held through stalls; `command_ready_o` returns to 1 after DE is accepted.
- `UART_RX_TIMEOUT_EN`, TIMEOUT_CYCLES=16: 2 bytes then 16 idle cycles → `rx_timeout_o` pulses once; next bytes 01,02,03,04 → 0x04030201.
- Reset asserted after 3 RX bytes and mid-TX lane 1 → all outputs at reset values; after release, 4 new bytes form a clean word and TX sits in idle.
